// File: rtl/clock_freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// clock_freq_meter_pkg
// Shared types and constants for the multi-channel frequency/event meter.
//   state_t          : measurement FSM states
//   WINDOW_ID_WIDTH  : width of the published window sequence number
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package clock_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam int WINDOW_ID_WIDTH = 8;

endpackage

// File: rtl/clock_freq_meter_sig_edge_sync.sv
// ---------------------------------------------------------------------------
// sig_edge_sync
// Brings one asynchronous signal into i_clk through a SYNC_STAGES-deep flop
// chain, then flags a rising edge with one extra delay flop.
//   i_clk  : sampling clock
//   i_rst  : asynchronous active-high reset (clears all flops)
//   i_sig  : asynchronous input
//   o_rise : one-cycle pulse per synchronised rising edge
// Latency from input change to o_rise is SYNC_STAGES cycles; the pulse is
// consumed by the counter on the following edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sig_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   delay_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_reg  <= '0;
      delay_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], i_sig};
      delay_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign o_rise = sync_reg[SYNC_STAGES-1] & ~delay_reg;

endmodule

// File: rtl/clock_freq_meter.sv
// ---------------------------------------------------------------------------
// clock_freq_meter
// Counts synchronised rising edges of NUM_CHANNELS asynchronous inputs over a
// gate window of G i_clk cycles and publishes saturating per-channel counts.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_sig           : measured asynchronous signals
//   i_gate_cycles   : window length G (sampled on start and on each rearm)
//   i_start         : begin a measurement (honoured only in IDLE, G != 0)
//   i_continuous    : rearm automatically after each published window
//   i_abort         : drop the current window and return to IDLE
//   o_busy          : high while measuring
//   o_valid         : one-cycle pulse when o_counts/o_overflow are new
//   o_counts        : channel n at [n*COUNTER_WIDTH +: COUNTER_WIDTH]
//   o_overflow      : channel saturated during the published window
//   o_window_id     : increments with each o_valid, wraps
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module clock_freq_meter
  import clock_freq_meter_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int GATE_WIDTH    = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_CHANNELS-1:0]               i_sig,
  input  logic [GATE_WIDTH-1:0]                 i_gate_cycles,
  input  logic                                  i_start,
  input  logic                                  i_continuous,
  input  logic                                  i_abort,
  output logic                                  o_busy,
  output logic                                  o_valid,
  output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] o_counts,
  output logic [NUM_CHANNELS-1:0]               o_overflow,
  output logic [WINDOW_ID_WIDTH-1:0]            o_window_id
);

  state_t                     state_reg, state_next;
  logic [GATE_WIDTH-1:0]      gate_cnt_reg, gate_cnt_next;
  logic [WINDOW_ID_WIDTH-1:0] window_id_reg;
  logic [NUM_CHANNELS-1:0]    rise;

  // Control strobes from the FSM to the per-channel datapath.
  logic win_load;   // start a fresh window (from IDLE or on rearm)
  logic rearm;      // window load happening in the PUBLISH cycle
  logic accum;      // counters accumulate edges this cycle
  logic latch_out;  // final cycle of a window: copy results to outputs

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      gate_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gate_cnt_reg <= gate_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gate_cnt_next = gate_cnt_reg;
    win_load      = 1'b0;
    rearm         = 1'b0;
    latch_out     = 1'b0;
    if (i_abort) begin
      // Abort wins over start, rearm and window end alike.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start && (i_gate_cycles != '0)) begin
            state_next    = MEASURE;
            gate_cnt_next = i_gate_cycles;
            win_load      = 1'b1;
          end
        end
        MEASURE: begin
          gate_cnt_next = gate_cnt_reg - GATE_WIDTH'(1);
          if (gate_cnt_reg == GATE_WIDTH'(1)) begin
            latch_out  = 1'b1;
            state_next = PUBLISH;
          end
        end
        PUBLISH: begin
          // A zero length at rearm would never terminate, so it ends the run.
          if (i_continuous && (i_gate_cycles != '0)) begin
            state_next    = MEASURE;
            gate_cnt_next = i_gate_cycles;
            win_load      = 1'b1;
            rearm         = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign accum   = (state_reg == MEASURE);
  assign o_busy  = (state_reg == MEASURE);
  assign o_valid = (state_reg == PUBLISH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      window_id_reg <= '0;
    end else if (latch_out) begin
      window_id_reg <= window_id_reg + WINDOW_ID_WIDTH'(1);
    end
  end

  assign o_window_id = window_id_reg;

  // -------------------------------------------------------------------------
  // Per-channel synchroniser, saturating counter and output register
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic [COUNTER_WIDTH-1:0] cnt_reg;
      logic                     ovf_reg;
      logic [COUNTER_WIDTH-1:0] cnt_out_reg;
      logic                     ovf_out_reg;
      logic                     at_max;
      logic [COUNTER_WIDTH-1:0] cnt_inc;
      logic                     ovf_inc;

      sig_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_sig (i_sig[gi]),
        .o_rise(rise[gi])
      );

      // Count including this cycle's edge; an edge arriving at all-ones is
      // the one that is lost, so that is what marks overflow.
      assign at_max  = &cnt_reg;
      assign cnt_inc = (rise[gi] && !at_max) ? cnt_reg + COUNTER_WIDTH'(1) : cnt_reg;
      assign ovf_inc = ovf_reg | (rise[gi] & at_max);

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (win_load) begin
          // On rearm the PUBLISH-cycle edge belongs to the new window.
          cnt_reg <= COUNTER_WIDTH'(rise[gi] & rearm);
          ovf_reg <= 1'b0;
        end else if (accum) begin
          cnt_reg <= cnt_inc;
          ovf_reg <= ovf_inc;
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          cnt_out_reg <= '0;
          ovf_out_reg <= 1'b0;
        end else if (latch_out) begin
          cnt_out_reg <= cnt_inc;
          ovf_out_reg <= ovf_inc;
        end
      end

      assign o_counts[gi*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_out_reg;
      assign o_overflow[gi]                              = ovf_out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clock_freq_meter.sv
`timescale 1ns/1ps
module tb_clock_freq_meter;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int GW  = 32;
  localparam int S   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk;
  logic              i_rst;
  logic [NCH-1:0]    i_sig;
  logic [GW-1:0]     i_gate_cycles;
  logic              i_start;
  logic              i_continuous;
  logic              i_abort;
  logic              o_busy;
  logic              o_valid;
  logic [NCH*CW-1:0] o_counts;
  logic [NCH-1:0]    o_overflow;
  logic [7:0]        o_window_id;

  clock_freq_meter #(
    .NUM_CHANNELS (NCH),
    .COUNTER_WIDTH(CW),
    .GATE_WIDTH   (GW),
    .SYNC_STAGES  (S)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_sig        (i_sig),
    .i_gate_cycles(i_gate_cycles),
    .i_start      (i_start),
    .i_continuous (i_continuous),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_counts     (o_counts),
    .o_overflow   (o_overflow),
    .o_window_id  (o_window_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sampled view of the inputs: entry n is what the first synchroniser flop
  // sees at rising edge n (reset forces it to 0).
  logic [NCH-1:0] hist[$];
  int cyc = 0;
  always @(posedge clk) begin
    hist.push_back(i_rst ? '0 : i_sig);
    cyc <= cyc + 1;
  end

  // Stimulus generator: half[c] = 0 static low, < 0 random, else toggle
  // every half[c] cycles.
  int half [NCH];
  int phase[NCH];
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (half[c] == 0) i_sig[c] = 1'b0;
      else if (half[c] < 0) i_sig[c] = 1'($urandom_range(0, 1));
      else begin
        phase[c] = phase[c] + 1;
        if (phase[c] >= half[c]) begin
          phase[c] = 0;
          i_sig[c] = ~i_sig[c];
        end
      end
    end
  end

  // Reference model state.
  int          wid_model = 0;
  logic [CW-1:0] exp_counts[NCH];
  logic [NCH-1:0] exp_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges of channel c counted by the counter at edges lo..hi: a rise in the
  // sampled view at index n reaches the counter at edge n+S.
  function automatic int rises(input int c, input int lo, input int hi);
    int r = 0;
    for (int m = lo; m <= hi; m++) begin
      if (m - S - 1 >= 0 && m - S < hist.size()) begin
        if (hist[m-S][c] && !hist[m-S-1][c]) r++;
      end
    end
    return r;
  endfunction

  task automatic start_window(input int g, output int k);
    i_gate_cycles = GW'(g);
    i_start = 1'b1;
    k = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Waits for the window loaded at edge k (length g, counting edges lo..k+g)
  // to publish, then checks timing and results against the model.
  task automatic expect_window(input string tag, input int k, input int g, input int lo);
    int seen = -1;
    int busy_bad = 0;
    int raw;
    logic [NCH-1:0] ovf;
    for (int t = 0; t < g + 20; t++) begin
      if (o_valid === 1'b1) begin
        seen = cyc;
        break;
      end
      if (cyc >= k + 1 && cyc <= k + g && o_busy !== 1'b1) busy_bad++;
      @(negedge clk);
    end
    check({tag, "_valid_cycle"}, 64'(seen), 64'(k + g + 1));
    check({tag, "_busy_gaps"}, 64'(busy_bad), 64'd0);
    if (seen < 0) return;
    wid_model = (wid_model + 1) % 256;
    check({tag, "_window_id"}, 64'(o_window_id), 64'(wid_model));
    ovf = '0;
    for (int c = 0; c < NCH; c++) begin
      raw = rises(c, lo, k + g);
      exp_counts[c] = (raw > CMAX) ? CW'(CMAX) : CW'(raw);
      ovf[c] = (raw > CMAX);
      check($sformatf("%s_count%0d", tag, c), 64'(o_counts[c*CW +: CW]), 64'(exp_counts[c]));
    end
    exp_ovf = ovf;
    check({tag, "_overflow"}, 64'(o_overflow), 64'(exp_ovf));
    $display("window %s: id=%0d cycle=%0d counts=%h overflow=%b", tag, o_window_id, seen, o_counts, o_overflow);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_counts"}, 64'(o_counts), 64'd0);
    check({tag, "_overflow"}, 64'(o_overflow), 64'd0);
    check({tag, "_window_id"}, 64'(o_window_id), 64'd0);
  endtask

  function automatic logic [NCH*CW-1:0] packed_exp();
    logic [NCH*CW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*CW +: CW] = exp_counts[c];
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, lo, hi, first_lo, g_cur, sum_obs, nvalid;
    i_rst = 1'b1;
    i_sig = '0;
    i_gate_cycles = '0;
    i_start = 1'b0;
    i_continuous = 1'b0;
    i_abort = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      half[c] = 0;
      phase[c] = 0;
      exp_counts[c] = '0;
    end
    exp_ovf = '0;

    // Reset state.
    repeat (6) @(negedge clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // One-shot: ch0 at f/10, ch1 static, ch2 every 4, ch3 random.
    half[0] = 5; half[1] = 0; half[2] = 2; half[3] = -1;
    repeat (10) @(negedge clk);
    start_window(1000, k);
    expect_window("oneshot", k, 1000, k + 1);
    check("oneshot_ch0_near_100", 64'((o_counts[0 +: CW] >= 99) && (o_counts[0 +: CW] <= 101)), 64'd1);
    @(negedge clk);
    check("oneshot_valid_pulse", 64'(o_valid), 64'd0);
    check("oneshot_idle_after", 64'(o_busy), 64'd0);

    // Continuous: five windows; length changed mid-window 3, mode dropped in window 5.
    i_continuous = 1'b1;
    start_window(100, k);
    lo = k + 1;
    first_lo = lo;
    hi = 0;
    sum_obs = 0;
    for (int w = 0; w < 5; w++) begin
      g_cur = (w >= 3) ? 60 : 100;
      if (w == 2) i_gate_cycles = GW'(60);
      if (w == 4) i_continuous = 1'b0;
      expect_window($sformatf("cont%0d", w), k, g_cur, lo);
      sum_obs += int'(o_counts[2*CW +: CW]);
      hi = k + g_cur;
      k = k + g_cur + 1;
      lo = k;
      @(negedge clk);
    end
    check("cont_ch2_total", 64'(sum_obs), 64'(rises(2, first_lo, hi)));
    check("cont_stops_busy", 64'(o_busy), 64'd0);
    check("cont_stops_valid", 64'(o_valid), 64'd0);
    check("cont_final_id", 64'(o_window_id), 64'd6);

    // Saturation: ch0 edge every 2 cycles over 600 cycles.
    half[0] = 1;
    start_window(600, k);
    expect_window("sat", k, 600, k + 1);
    check("sat_ch0_max", 64'(o_counts[0 +: CW]), 64'(CMAX));
    check("sat_ovf0", 64'(o_overflow[0]), 64'd1);
    @(negedge clk);

    // Abort at cycle 200 of a 500-cycle window.
    half[0] = 5;
    start_window(500, k);
    repeat (199) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_busy", 64'(o_busy), 64'd0);
    nvalid = 0;
    for (int t = 0; t < 400; t++) begin
      if (o_valid !== 1'b0) nvalid++;
      @(negedge clk);
    end
    check("abort_no_valid", 64'(nvalid), 64'd0);
    check("abort_counts_kept", 64'(o_counts), 64'(packed_exp()));
    check("abort_ovf_kept", 64'(o_overflow), 64'(exp_ovf));
    check("abort_id_kept", 64'(o_window_id), 64'(wid_model));
    $display("abort: busy=%0d counts=%h id=%0d", o_busy, o_counts, o_window_id);

    // Start with G == 0 is ignored.
    i_gate_cycles = '0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("zero_g_busy", 64'(o_busy), 64'd0);
    nvalid = 0;
    for (int t = 0; t < 20; t++) begin
      if (o_valid !== 1'b0 || o_busy !== 1'b0) nvalid++;
      @(negedge clk);
    end
    check("zero_g_stays_idle", 64'(nvalid), 64'd0);
    $display("zero_g start: busy=%0d", o_busy);

    // Repeated start during MEASURE leaves the window length alone.
    start_window(150, k);
    repeat (49) @(negedge clk);
    i_gate_cycles = GW'(30);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    expect_window("restart_ignored", k, 150, k + 1);
    @(negedge clk);

    // Reset in the middle of a window.
    start_window(100, k);
    repeat (49) @(negedge clk);
    i_rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    wid_model = 0;
    repeat (5) @(negedge clk);
    nvalid = (o_valid !== 1'b0) ? 1 : 0;
    i_rst = 1'b0;
    for (int t = 0; t < 120; t++) begin
      if (o_valid !== 1'b0) nvalid++;
      @(negedge clk);
    end
    check("midreset_no_valid", 64'(nvalid), 64'd0);
    $display("reset mid-window: busy=%0d id=%0d", o_busy, o_window_id);

    // Fresh one-shot after reset.
    half[0] = 5; half[1] = 0; half[2] = 2; half[3] = -1;
    start_window(1000, k);
    expect_window("post_reset", k, 1000, k + 1);
    check("post_reset_ch1", 64'(o_counts[CW +: CW]), 64'd0);
    @(negedge clk);
    check("post_reset_idle", 64'(o_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
